// File: rtl/path_lock_arbiter.sv
// Reservation manager for the shared tour-path index space.
// Grants contiguous wrap-around slot windows atomically, round-robin, one requester per cycle.
module path_lock_arbiter #(
  parameter int NREQ   = 8,
  parameter int NSLOT  = 64,
  parameter int IDX_W  = 6,
  parameter int MAXLEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*IDX_W-1:0] req_idx_a_i,
  input  logic [NREQ*3-1:0]     req_len_a_i,
  input  logic [NREQ*IDX_W-1:0] req_idx_b_i,
  input  logic [NREQ*3-1:0]     req_len_b_i,
  input  logic [NREQ-1:0]       release_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [NREQ-1:0]       held_o,
  output logic [NSLOT-1:0]      locked_o,
  output logic [IDX_W:0]        lock_count_o,
  output logic                  err_o
);

  localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NSLOT-1:0] locked_q, locked_d;
  logic [NREQ-1:0]  held_q, held_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NSLOT-1:0] owner_q [NREQ];
  logic [NSLOT-1:0] owner_d [NREQ];
  logic [RR_W-1:0]  rr_q, rr_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             err_q, err_d;

  logic [NSLOT-1:0] reqMask [NREQ];
  logic [NREQ-1:0]  eligible;
  logic             winFound;
  logic [RR_W-1:0]  winIdx;
  logic [RR_W-1:0]  cand;

  // Lengths beyond MAXLEN are clamped; slot index wraps modulo NSLOT.
  function automatic logic [NSLOT-1:0] windowMask(input logic [IDX_W-1:0] idx,
                                                  input logic [2:0] len);
    logic [NSLOT-1:0] m;
    logic [2:0]       eff;
    logic [IDX_W-1:0] slot;
    m   = '0;
    eff = (len > 3'(MAXLEN)) ? 3'(MAXLEN) : len;
    for (int k = 0; k < MAXLEN; k++) begin
      slot = idx + IDX_W'(k);
      if (k < int'(eff)) m[slot] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      reqMask[i] = windowMask(req_idx_a_i[i*IDX_W +: IDX_W], req_len_a_i[i*3 +: 3])
                 | windowMask(req_idx_b_i[i*IDX_W +: IDX_W], req_len_b_i[i*3 +: 3]);
      eligible[i] = req_valid_i[i] & ~held_q[i] & ~|(reqMask[i] & locked_q);
    end
  end

  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = RR_W'((int'(rr_q) + off) % NREQ);
      if (!winFound && eligible[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
    end
  end

  // Eligibility sees only the registered lock map, so slots freed this cycle cannot be re-granted until the next.
  always_comb begin
    locked_d = locked_q;
    held_d   = held_q;
    grant_d  = '0;
    rr_d     = rr_q;
    err_d    = err_q;
    count_d  = '0;
    for (int i = 0; i < NREQ; i++) owner_d[i] = owner_q[i];

    for (int i = 0; i < NREQ; i++) begin
      if (release_i[i] && !held_q[i]) err_d = 1'b1;
      if (req_valid_i[i] && held_q[i] && !grant_q[i]) err_d = 1'b1;
    end

    if (flush_i) begin
      locked_d = '0;
      held_d   = '0;
      rr_d     = '0;
      for (int i = 0; i < NREQ; i++) owner_d[i] = '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (release_i[i] && held_q[i]) begin
          locked_d   = locked_d & ~owner_q[i];
          held_d[i]  = 1'b0;
          owner_d[i] = '0;
        end
      end
      if (winFound) begin
        locked_d        = locked_d | reqMask[winIdx];
        owner_d[winIdx] = reqMask[winIdx];
        held_d[winIdx]  = 1'b1;
        grant_d[winIdx] = 1'b1;
        rr_d            = RR_W'((int'(winIdx) + 1) % NREQ);
      end
    end

    for (int s = 0; s < NSLOT; s++) count_d = count_d + {{IDX_W{1'b0}}, locked_d[s]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= '0;
      held_q   <= '0;
      grant_q  <= '0;
      rr_q     <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NREQ; i++) owner_q[i] <= '0;
    end else begin
      locked_q <= locked_d;
      held_q   <= held_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      for (int i = 0; i < NREQ; i++) owner_q[i] <= owner_d[i];
    end
  end

  assign grant_o      = grant_q;
  assign held_o       = held_q;
  assign locked_o     = locked_q;
  assign lock_count_o = count_q;
  assign err_o        = err_q;

endmodule
